// File: rtl/reg_wr_arbiter_amisha_pkg.sv
// Shared types and defaults for the round-robin register write arbiter.
// The optional lock feature is controlled by the ARB_LOCK_EN macro in the top module.
package reg_wr_arb_pkg_amisha;

    localparam int DEF_N        = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_LOCK_MAX = 4;
    localparam int DEF_PTR_W    = $clog2(DEF_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/reg_wr_arbiter_amisha_if.sv
// Request/grant bundle between the requesting stages (master) and the arbiter (slave).
interface reg_wr_arbiter_amisha_if
    import reg_wr_arb_pkg_amisha::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
);
    logic [N-1:0]       req_amisha;
    logic [N*WIDTH-1:0] wdata_amisha;
    logic [N-1:0]       lock_amisha;
    logic [N-1:0]       gnt_amisha;
    logic [WIDTH-1:0]   q_amisha;
    logic               busy_amisha;

    modport master (
        output req_amisha, wdata_amisha, lock_amisha,
        input  gnt_amisha, q_amisha, busy_amisha
    );

    modport slave (
        input  req_amisha, wdata_amisha, lock_amisha,
        output gnt_amisha, q_amisha, busy_amisha
    );
endinterface

// File: rtl/reg_wr_arbiter_amisha_en_cell.sv
// Shared storage: WIDTH-bit register with synchronous active-low reset and a load enable.
module reg_en_cell_amisha #(
    parameter int WIDTH = 8
) (
    input  logic             clk_amisha,
    input  logic             reset_n_amisha,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch,
    // and all state uses non-blocking assignment to avoid ordering races between flops.
    always_ff @(posedge clk_amisha) begin
        if (!reset_n_amisha) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/reg_wr_arbiter_amisha.sv
// Round-robin write arbiter owning a single shared register; define ARB_LOCK_EN to
// compile in the LOCK state that holds a grant for up to LOCK_MAX cycles.
module reg_wr_arbiter_amisha
    import reg_wr_arb_pkg_amisha::*;
#(
    parameter int N        = DEF_N,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input logic                    clk_amisha,
    input logic                    reset_n_amisha,
    reg_wr_arbiter_amisha_if.slave bus
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    arb_state_e       state;
    logic [N-1:0]     gnt;
    logic [N-1:0]     cand;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;
    logic             found;
    logic             hold;
    logic             busy;
    logic [WIDTH-1:0] wsel;

`ifdef ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0] lock_cnt;
`else
    logic unused_lock;
    assign unused_lock = ^bus.lock_amisha;
`endif

    // The current grantee is masked so it can never win two grants in a row.
    assign cand = bus.req_amisha & ~gnt;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && cand[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = PTR_W'((int'(ptr) + k) % N);
            end
        end
    end

    always_comb begin
        hold = 1'b0;
`ifdef ARB_LOCK_EN
        if (state == GRANT) begin
            hold = bus.lock_amisha[idx] && (LOCK_MAX > 1);
        end else if (state == LOCK) begin
            hold = bus.lock_amisha[idx] && (lock_cnt != CNT_W'(LOCK_MAX - 1));
        end
`endif
    end

    always_ff @(posedge clk_amisha) begin
        if (!reset_n_amisha) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
            idx   <= '0;
`ifdef ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else if (hold) begin
`ifdef ARB_LOCK_EN
            state    <= LOCK;
            lock_cnt <= lock_cnt + 1'b1;
`endif
        end else begin
`ifdef ARB_LOCK_EN
            lock_cnt <= '0;
`endif
            if (found) begin
                state <= GRANT;
                gnt   <= N'(1) << win;
                idx   <= win;
                ptr   <= (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
            end else begin
                state <= IDLE;
                gnt   <= '0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign wsel = bus.wdata_amisha[idx*WIDTH +: WIDTH];

    reg_en_cell_amisha #(.WIDTH(WIDTH)) u_cell (
        .clk_amisha     (clk_amisha),
        .reset_n_amisha (reset_n_amisha),
        .en             (busy),
        .d              (wsel),
        .q              (bus.q_amisha)
    );

    assign bus.gnt_amisha  = gnt;
    assign bus.busy_amisha = busy;
endmodule

// File: doc/reg_wr_arbiter_amisha.md
# reg_wr_arbiter_amisha

Round-robin write arbiter that shares a single enabled register among N requesters. Each cycle at most one requester is granted. The granted requester's data is loaded through the register's enable path, so the shared register is only written under arbiter control. The block sits between requesting datapath stages and a common configuration/data register, and replaces ad-hoc enable muxing.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- WIDTH, 8, register data width
- LOCK_MAX, 4, maximum consecutive cycles a locked grant may be held (only used with ARB_LOCK_EN)

Ports:
- clk_amisha  input  1  single clock; all state updates on posedge
- reset_n_amisha  input  1  synchronous, active-low reset, sampled on posedge clk_amisha
- req_amisha  input  N  per-requester write request; held high until granted
- wdata_amisha  input  N*WIDTH  packed write data; requester i owns bits [i*WIDTH +: WIDTH]
- lock_amisha  input  N  per-requester lock request (ignored unless ARB_LOCK_EN)
- gnt_amisha  output  N  one-hot (or zero) registered grant
- q_amisha  output  WIDTH  shared register contents
- busy_amisha  output  1  high whenever gnt_amisha is nonzero

## Operation
- Reset (reset_n_amisha low at posedge) clears the following:
  - gnt_amisha = 0, q_amisha = 0, busy_amisha = 0.
  - FSM goes to IDLE.
  - Priority pointer = 0, so requester 0 has highest priority.
  - Lock counter = 0.
- Reset mid-grant aborts the grant. No write occurs in the reset cycle.
- Arbitration: the candidate set is req_amisha & ~gnt_amisha. The current grantee is masked so it cannot be re-granted back-to-back.
- The winner is the first set bit at or after the pointer, searching with wrap-around from N-1 to 0.
- When a grant is issued to requester i, the pointer becomes (i+1) mod N.
- FSM states:
  - IDLE: gnt = 0. Go to GRANT if the candidate set is nonzero, otherwise stay in IDLE.
  - GRANT: gnt one-hot for exactly one cycle. The shared register enable is asserted and q loads the grantee's wdata slice at the closing edge. Next state:
    - LOCK if ARB_LOCK_EN and lock_amisha[grantee] is high.
    - Otherwise GRANT with a new winner if the candidate set is nonzero.
    - Otherwise IDLE.
  - LOCK (ARB_LOCK_EN only): gnt is held on the same requester and a write occurs every cycle. The lock counter increments each cycle. Exit when lock_amisha[grantee] goes low or the counter reaches LOCK_MAX-1. The exit target is GRANT or IDLE, chosen by the same rule as in GRANT. The lock counter clears on exit.
- The register enable equals busy_amisha. There are no writes in IDLE.
- Requester protocol:
  - Deassert req the cycle after seeing gnt, or keep it high to queue another write.
  - A held req re-enters arbitration at lower priority because the pointer has moved past it.
- Requests arriving while gnt is active are arbitrated for the next cycle. Simultaneous requests are resolved by the pointer only.
- All-requesters-high steady state: grants rotate 0,1,2,…,N-1,0 with one grant per cycle and no idle cycles.

## Timing
- Request to grant latency: req sampled high at edge k gives gnt high during cycle k+1.
- Grant to data latency: q updates at the edge ending the grant cycle, i.e. visible in cycle k+2.
- wdata must be valid during the grant cycle. Only the grantee's slice is sampled.
- Throughput: one write per cycle maximum.
- Lock:
  - A lock holds the grant for at most LOCK_MAX cycles, counting the initial GRANT cycle.
  - Worst-case wait for any requester is (N-1)*LOCK_MAX cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- ARB_LOCK_EN defined: the LOCK state, the lock counter and the LOCK_MAX bound are compiled in. lock_amisha is honoured.
- ARB_LOCK_EN undefined:
  - The LOCK state and counter are absent and lock_amisha is unused.
  - Every grant lasts exactly one cycle.
  - LOCK_MAX is ignored.

## Structure
- Shared package reg_wr_arb_pkg_amisha contains:
  - the FSM state enum (IDLE, GRANT, LOCK);
  - default N/WIDTH/LOCK_MAX constants;
  - a pointer-width constant, clog2(N).
- Sub-module reg_en_cell_amisha holds the shared storage:
  - WIDTH-bit register with synchronous active-low reset and a load enable;
  - instantiated once, driven by busy_amisha and the muxed grantee slice.

## Test plan
- Reset: drive all req=4'b1111 with reset_n low for 3 cycles -> gnt=0, q=0, busy=0 throughout. First grant after release goes to requester 0.
- Single request: req=4'b0100, wdata slice 2=8'hA5 -> gnt=4'b0100 in cycle k+1, q=8'hA5 in cycle k+2. Then IDLE once req drops.
- Full contention: req=4'b1111 held, slices 8'h10/11/12/13 -> gnt sequence 0001,0010,0100,1000,0001. q follows 10,11,12,13 one cycle behind.
- Wrap and fairness: pointer at 3 after granting 2, req=4'b0011 -> grant 0 then 1. Requester 3 is never granted while idle.
- Lock (ARB_LOCK_EN, LOCK_MAX=4): req1 and lock1 held high, req0 high -> gnt=0010 for exactly 4 cycles, then 0001. Rebuild without macro -> gnt=0010 for 1 cycle.
- Reset mid-lock: reset_n low during the 2nd LOCK cycle -> next cycle gnt=0, q=0, pointer=0, counter=0.
